// File: rtl/cache_traffic_gen.sv
// Cache traffic generator: issues NUM_ACCESS requests from START_ADDR, then reports floor(hits*100/NUM_ACCESS).
// Optional feature macro: CACHE_TRAFFIC_WRITE_EN (every WR_EVERY-th access becomes a write).
module cache_traffic_gen #(
  parameter int ADDR_W     = 15,
  parameter int CNT_W      = 14,
  parameter int NUM_ACCESS = 8192,
  parameter int START_ADDR = 1024,
  parameter int STRIDE     = 1,
  parameter int WR_EVERY   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              cache_ready,
  input  logic [CNT_W-1:0]  hit_count,
  output logic              cache_read,
  output logic              cache_write,
  output logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              done,
  output logic [6:0]        hit_rate
);

  localparam int                PW       = CNT_W + 7;
  localparam logic [CNT_W-1:0]  NUM_C    = CNT_W'(NUM_ACCESS);
  localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(NUM_ACCESS - 1);
  localparam logic [PW-1:0]     DIV_BASE = PW'(NUM_ACCESS) << 6;
  localparam logic [ADDR_W-1:0] START_C  = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(STRIDE);

  if (NUM_ACCESS < 1 || NUM_ACCESS > (2 ** CNT_W) - 1) begin : g_bad_num_access
    $error("NUM_ACCESS must lie in 1..2^CNT_W-1");
  end
  if (WR_EVERY < 1) begin : g_bad_wr_every
    $error("WR_EVERY must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, CALC, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mode;
  logic [PW-1:0]     r_rem;
  logic [5:0]        r_quo;
  logic [2:0]        r_iter;
  logic [6:0]        r_hit_rate;

  logic              w_start_ok;
  logic              w_accept;
  logic              w_last;
  logic              w_is_write;
  logic              w_qbit;
  logic [CNT_W-1:0]  w_hit_sat;
  logic [PW-1:0]     w_prod;
  logic [PW-1:0]     w_div;
  logic [6:0]        w_quo_next;

  // Handshake: a request is valid while cache_read or cache_write is high; it transfers on a
  // rising edge where cache_ready is also high, and request/address hold unchanged until then.
  assign w_start_ok = start && (r_state == IDLE || r_state == DONE);
  assign w_accept   = (r_state == ISSUE) && cache_ready;
  assign w_last     = (r_cnt == LAST_C);

  // Restoring divide: bit i of the quotient tests the remainder against NUM_ACCESS << i.
  assign w_hit_sat  = (hit_count > NUM_C) ? NUM_C : hit_count;
  assign w_prod     = PW'(w_hit_sat) * PW'(100);
  assign w_div      = DIV_BASE >> r_iter;
  assign w_qbit     = (r_rem >= w_div);
  assign w_quo_next = {r_quo, w_qbit};

`ifdef CACHE_TRAFFIC_WRITE_EN
  localparam int              PH_W    = (WR_EVERY > 1) ? $clog2(WR_EVERY) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(WR_EVERY - 1);

  logic [PH_W-1:0] r_phase;

  assign w_is_write = (r_phase == PH_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else if (w_start_ok) begin
      r_phase <= '0;
    end else if (w_accept) begin
      r_phase <= w_is_write ? '0 : r_phase + 1'b1;
    end
  end
`else
  assign w_is_write = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = ISSUE;
      end
      ISSUE: begin
        busy        = 1'b1;
        cache_read  = !w_is_write;
        cache_write = w_is_write;
        if (w_accept && w_last) w_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (r_iter == 3'd6) w_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_next = ISSUE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= START_C;
      r_cnt      <= '0;
      r_mode     <= 1'b0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_iter     <= '0;
      r_hit_rate <= '0;
    end else begin
      if (w_start_ok) begin
        r_addr <= START_C;
        r_cnt  <= '0;
        r_mode <= mode;
      end else if (w_accept) begin
        r_addr <= r_addr + (r_mode ? STRIDE_C : ADDR_W'(1));
        r_cnt  <= r_cnt + 1'b1;
      end

      // The hit counter is sampled exactly once, on the edge that accepts the final access.
      if (w_accept && w_last) begin
        r_rem  <= w_prod;
        r_quo  <= '0;
        r_iter <= '0;
      end else if (r_state == CALC) begin
        if (w_qbit) r_rem <= r_rem - w_div;
        r_quo  <= w_quo_next[5:0];
        r_iter <= r_iter + 1'b1;
        if (r_iter == 3'd6) r_hit_rate <= w_quo_next;
      end
    end
  end

  assign address  = r_addr;
  assign hit_rate = r_hit_rate;

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Bench for cache_traffic_gen: random ready/hit stimulus, request and result scoreboards fed by a
// reference model of the address/write sequence and the percentage formula.
module tb_cache_traffic_gen;

  localparam int ADDR_W     = 5;
  localparam int CNT_W      = 6;
  localparam int NUM_ACCESS = 13;
  localparam int START_ADDR = 24;
  localparam int STRIDE     = 7;
  localparam int WR_EVERY   = 3;
  localparam int CALC_CYC   = 7;

  logic              clk;
  logic              rst;
  logic              start;
  logic              mode;
  logic              cache_ready;
  logic [CNT_W-1:0]  hit_count;
  logic              cache_read;
  logic              cache_write;
  logic [ADDR_W-1:0] address;
  logic              busy;
  logic              done;
  logic [6:0]        hit_rate;

  int n_pass    = 0;
  int n_total   = 0;
  int cyc       = 0;
  int last_acc  = 0;
  int n_acc_run = 0;
  logic [6:0]    held_rate = '0;
  logic [ADDR_W:0] exp_q[$];
  logic [6:0]      res_q[$];

  cache_traffic_gen #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .NUM_ACCESS(NUM_ACCESS),
    .START_ADDR(START_ADDR), .STRIDE(STRIDE), .WR_EVERY(WR_EVERY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .cache_ready(cache_ready),
    .hit_count(hit_count), .cache_read(cache_read), .cache_write(cache_write),
    .address(address), .busy(busy), .done(done), .hit_rate(hit_rate)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: access k lands at START + k*step (mod 2^ADDR_W).
  function automatic logic [ADDR_W:0] model_access(input int k, input bit m);
    int   step;
    int   a;
    logic wr;
    step = m ? STRIDE : 1;
    a    = (START_ADDR + k * step) % (1 << ADDR_W);
    wr   = 1'b0;
`ifdef CACHE_TRAFFIC_WRITE_EN
    wr = ((k % WR_EVERY) == WR_EVERY - 1);
`endif
    return {wr, ADDR_W'(a)};
  endfunction

  function automatic logic [6:0] model_rate(input int h);
    int sat;
    sat = (h > NUM_ACCESS) ? NUM_ACCESS : h;
    return 7'((sat * 100) / NUM_ACCESS);
  endfunction

  // Random ready, changed just after each rising edge.
  initial begin
    cache_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 cache_ready = ($urandom_range(0, 9) < 6);
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    logic              prev_pending;
    logic              prev_done;
    logic [ADDR_W+1:0] prev_sig;
    logic [ADDR_W:0]   e;
    logic              req;
    prev_pending = 1'b0;
    prev_done    = 1'b0;
    prev_sig     = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_pending = 1'b0;
        prev_done    = 1'b0;
      end else begin
        req = cache_read | cache_write;
        check("req_legal", {31'd0, !(cache_read && cache_write) && (!req || busy)}, 1);
        if (prev_pending) check("req_stable", {cache_write, cache_read, address}, prev_sig);
        if (req && cache_ready) begin
          n_acc_run++;
          last_acc = cyc;
          if (exp_q.size() == 0) begin
            check("extra_access", {cache_write, address}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("access", {cache_write, address}, e);
          end
        end
        prev_pending = req && !cache_ready;
        prev_sig     = {cache_write, cache_read, address};
        if (done && !prev_done) begin
          check("done_latency", cyc - last_acc - 1, CALC_CYC);
          check("done_not_busy", busy, 0);
          check("accesses_left", exp_q.size(), 0);
          if (res_q.size() == 0) check("spurious_done", done, 0);
          else held_rate = res_q.pop_front();
        end
        check("hit_rate", hit_rate, held_rate);
        prev_done = done;
      end
    end
  end

  // Driver tasks
  task automatic begin_run(input int h, input bit m);
    hit_count = CNT_W'(h);
    mode      = m;
    start     = 1'b1;
    for (int k = 0; k < NUM_ACCESS; k++) exp_q.push_back(model_access(k, m));
    res_q.push_back(model_rate(h));
    n_acc_run = 0;
    @(posedge clk);
    #1 start = 1'b0;
    check("done_cleared", done, 0);
    check("busy_on_start", busy, 1);
  endtask

  task automatic run_once(input int h, input bit m, input bit inject);
    int calc_seen;
    calc_seen = 0;
    begin_run(h, m);
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk);
      #1;
      mode = $urandom_range(0, 1);
      if (busy && !cache_read && !cache_write) calc_seen++;
      start = inject && (i == 2 || calc_seen == 1);
      if (calc_seen == 2) hit_count = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
    end
    start = 1'b0;
    check("run_timeout", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_read", cache_read, 0);
    check("rst_write", cache_write, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hit_rate", hit_rate, 0);
    check("rst_address", address, START_ADDR);
  endtask

  task automatic reset_mid(input int h, input bit in_calc);
    bit reached;
    reached = 1'b0;
    begin_run(h, 1'b1);
    for (int i = 0; i < 2000 && !reached; i++) begin
      @(posedge clk);
      #1;
      if (!in_calc && n_acc_run >= 2 && busy && (cache_read || cache_write)) reached = 1'b1;
      if (in_calc && busy && !cache_read && !cache_write) reached = 1'b1;
    end
    check(in_calc ? "reach_calc" : "reach_issue", reached, 1);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    exp_q.delete();
    res_q.delete();
    held_rate = '0;
    check_reset_outputs();
    @(posedge clk);
    #1 check("start_with_rst_ignored", busy, 0);
  endtask

  // Main sequence
  initial begin : main
    int hits[5];
    hits = '{1, 13, 40, 0, 63};
    rst       = 1'b1;
    start     = 1'b1;
    mode      = 1'b0;
    hit_count = '0;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    check_reset_outputs();
    @(posedge clk);
    #1 check("idle_after_reset", busy, 0);

    for (int r = 0; r < 5; r++) run_once(hits[r], r[0], r == 1 || r == 3);
    for (int r = 0; r < 5; r++) run_once($urandom_range(0, (1 << CNT_W) - 1), $urandom_range(0, 1), r[0]);

    reset_mid(7, 1'b0);
    reset_mid(9, 1'b1);
    run_once(6, 1'b1, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    check("done_held", done, 1);
    check("done_held_busy", busy, 0);
    check("queues_drained", exp_q.size() + res_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
